// File: rtl/cmd_pkg.sv
// Command codes shared by the sequencer and the command muxer, plus the sequencer state encoding.
package cmd_pkg;

  typedef logic [7:0] cmd_code_t;

  localparam cmd_code_t CMD_IDLE         = 8'h01;
  localparam cmd_code_t CMD_RESET_LO     = 8'h02;
  localparam cmd_code_t CMD_RESET_HI     = 8'h03;
  localparam cmd_code_t CMD_SREG_EN_LO   = 8'h04;
  localparam cmd_code_t CMD_SREG_EN_HI   = 8'h05;
  localparam cmd_code_t CMD_SI_LO        = 8'h06;
  localparam cmd_code_t CMD_SI_HI        = 8'h07;
  localparam cmd_code_t CMD_OE_LO        = 8'h08;
  localparam cmd_code_t CMD_OE_HI        = 8'h09;
  localparam cmd_code_t CMD_WE_LO        = 8'h0A;
  localparam cmd_code_t CMD_WE_HI        = 8'h0B;
  localparam cmd_code_t CMD_COUNTER_LO   = 8'h0C;
  localparam cmd_code_t CMD_COUNTER_HI   = 8'h0D;
  localparam cmd_code_t CMD_SNES_MODE_LO = 8'h0E;
  localparam cmd_code_t CMD_SNES_MODE_HI = 8'h0F;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_SREG_OPEN,
    ST_SHIFT,
    ST_SREG_CLOSE,
    ST_STROBE_LO,
    ST_STROBE_HI,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DONE
  } seq_state_t;

  // Steps 1..4 of the post-reset sequence park every control line in its inactive level.
  function automatic cmd_code_t init_code(input logic [2:0] step);
    case (step)
      3'd1:    init_code = CMD_OE_HI;
      3'd2:    init_code = CMD_WE_HI;
      3'd3:    init_code = CMD_SREG_EN_HI;
      3'd4:    init_code = CMD_COUNTER_HI;
      default: init_code = CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/command_sequencer_if.sv
// Request handshake and command-output bundle between a requester and command_sequencer.
interface command_sequencer_if
  import cmd_pkg::*;
#(
  parameter int ADDR_W = 24
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              byte_strobe;
  logic              done;
  cmd_code_t         avr_ctrl;

  modport master (
    output req_valid, req_write, req_addr, req_len,
    input  req_ready, byte_strobe, done, avr_ctrl
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    output req_ready, byte_strobe, done, avr_ctrl
  );
endinterface

// File: rtl/cmd_seq_shifter.sv
// Address shift register: loads a start address, shifts MSB first and flags the final bit.
module cmd_seq_shifter #(
  parameter int ADDR_W = 24
) (
  input  logic              avr_clk,
  input  logic              avr_reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              shift,
  output logic              msb,
  output logic              last_bit
);
  localparam int CNT_W = $clog2(ADDR_W + 1);

  logic [ADDR_W-1:0] sreg;
  logic [CNT_W-1:0]  bit_cnt;

  // The counter saturates at ADDR_W so stray shifts after the last bit never wrap the flag.
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= load_value;
      bit_cnt <= '0;
    end else if (shift) begin
      sreg <= sreg << 1;
      if (bit_cnt != CNT_W'(ADDR_W))
        bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign msb      = sreg[ADDR_W-1];
  assign last_bit = (bit_cnt == CNT_W'(ADDR_W - 1));

endmodule

// File: rtl/command_sequencer.sv
// Turns read/write requests into the AVR command-code stream (address shift, OE/WE strobes, counter bumps).
// Define CMD_SEQ_BURST_EN to honour req_len; without it every transfer is a single byte.
module command_sequencer
  import cmd_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int ADDR_W        = 24
) (
  input  logic                avr_clk,
  input  logic                avr_reset,
  command_sequencer_if.slave  bus
);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES);

  seq_state_t state, state_d;
  logic [2:0] init_step, init_step_d;
  logic [3:0] strobe_cnt, strobe_cnt_d;
  logic [8:0] bytes_left, bytes_left_d;
  logic       is_write, is_write_d;
  logic       shift_last, shift_last_d;
  cmd_code_t  ctrl_d;
  logic       ready_d, strobe_d, done_d;
  logic       load, shift_en, msb, last_bit, more_bytes;

  cmd_seq_shifter #(.ADDR_W(ADDR_W)) u_shifter (
    .avr_clk    (avr_clk),
    .avr_reset  (avr_reset),
    .load       (load),
    .load_value (bus.req_addr),
    .shift      (shift_en),
    .msb        (msb),
    .last_bit   (last_bit)
  );

`ifdef CMD_SEQ_BURST_EN
  assign more_bytes = (bytes_left > 9'd1);
`else
  assign more_bytes = 1'b0;
`endif

  // Outputs are decoded from the next state so the registered avr_ctrl lines up with the state it names.
  always_comb begin
    state_d      = state;
    init_step_d  = init_step;
    strobe_cnt_d = strobe_cnt;
    bytes_left_d = bytes_left;
    is_write_d   = is_write;
    shift_last_d = shift_last;
    load         = 1'b0;
    ctrl_d       = CMD_IDLE;
    strobe_d     = 1'b0;
    done_d       = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_step == 3'd4) begin
          state_d = ST_IDLE;
        end else begin
          init_step_d = init_step + 3'd1;
          ctrl_d      = init_code(init_step_d);
        end
      end
      ST_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          load         = 1'b1;
          is_write_d   = bus.req_write;
          bytes_left_d = (bus.req_len == 8'd0) ? 9'd256 : {1'b0, bus.req_len};
          state_d      = ST_SREG_OPEN;
          ctrl_d       = CMD_SREG_EN_LO;
        end
      end
      ST_SREG_OPEN, ST_SHIFT: begin
        if (state == ST_SHIFT && shift_last) begin
          state_d = ST_SREG_CLOSE;
          ctrl_d  = CMD_SREG_EN_HI;
        end else begin
          state_d      = ST_SHIFT;
          ctrl_d       = msb ? CMD_SI_HI : CMD_SI_LO;
          shift_last_d = last_bit;
        end
      end
      ST_SREG_CLOSE, ST_CNT_HI: begin
        state_d      = ST_STROBE_LO;
        strobe_cnt_d = 4'd1;
        ctrl_d       = is_write ? CMD_WE_LO : CMD_OE_LO;
        strobe_d     = (strobe_cnt_d == STROBE_LAST);
      end
      ST_STROBE_LO: begin
        if (strobe_cnt == STROBE_LAST) begin
          state_d = ST_STROBE_HI;
          ctrl_d  = is_write ? CMD_WE_HI : CMD_OE_HI;
        end else begin
          strobe_cnt_d = strobe_cnt + 4'd1;
          ctrl_d       = is_write ? CMD_WE_LO : CMD_OE_LO;
          strobe_d     = (strobe_cnt_d == STROBE_LAST);
        end
      end
      ST_STROBE_HI: begin
        if (more_bytes) begin
          state_d      = ST_CNT_LO;
          bytes_left_d = bytes_left - 9'd1;
          ctrl_d       = CMD_COUNTER_LO;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_CNT_LO: begin
        state_d = ST_CNT_HI;
        ctrl_d  = CMD_COUNTER_HI;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_INIT;
        init_step_d = 3'd0;
      end
    endcase
    ready_d  = (state_d == ST_IDLE);
    shift_en = (state_d == ST_SHIFT);
  end

  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state           <= ST_INIT;
      init_step       <= 3'd0;
      strobe_cnt      <= 4'd0;
      bytes_left      <= 9'd0;
      is_write        <= 1'b0;
      shift_last      <= 1'b0;
      bus.avr_ctrl    <= CMD_IDLE;
      bus.req_ready   <= 1'b0;
      bus.byte_strobe <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state           <= state_d;
      init_step       <= init_step_d;
      strobe_cnt      <= strobe_cnt_d;
      bytes_left      <= bytes_left_d;
      is_write        <= is_write_d;
      shift_last      <= shift_last_d;
      bus.avr_ctrl    <= ctrl_d;
      bus.req_ready   <= ready_d;
      bus.byte_strobe <= strobe_d;
      bus.done        <= done_d;
    end
  end

endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench for command_sequencer: reset/INIT sequence, single reads, bursts, held req_valid, mid-transfer reset.
module tb_command_sequencer;
  localparam int ADDR_W = 24;

  logic avr_clk   = 1'b0;
  logic avr_reset = 1'b1;

  command_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  command_sequencer #(.STROBE_CYCLES(2), .ADDR_W(ADDR_W)) dut (
    .avr_clk   (avr_clk),
    .avr_reset (avr_reset),
    .bus       (bus.slave)
  );

  always #5 avr_clk = ~avr_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] trace[$];
  int done_t, strobe_cnt, first_strobe_t, done_cnt, ready_seen;

  task automatic step();
    @(posedge avr_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents a request, waits (bounded) for req_ready, and returns one cycle after the handshake edge (T1).
  task automatic applyStimulus(input logic write, input logic [23:0] addr, input logic [7:0] len, input logic keep_valid);
    int waited = 0;
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_len   = len;
    while (bus.req_ready !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    checkOutput("handshake_ready", {31'd0, bus.req_ready}, 32'd1);
    step();
    if (!keep_valid) bus.req_valid = 1'b0;
  endtask

  // Records avr_ctrl from T1 onward until the done pulse or the cycle budget runs out.
  task automatic runUntilDone(input int budget);
    int t = 1;
    trace.delete();
    done_t = 0; strobe_cnt = 0; first_strobe_t = 0; done_cnt = 0; ready_seen = 0;
    while (t <= budget) begin
      trace.push_back(bus.avr_ctrl);
      if (bus.req_ready === 1'b1) ready_seen++;
      if (bus.byte_strobe === 1'b1) begin
        strobe_cnt++;
        if (first_strobe_t == 0) first_strobe_t = t;
      end
      if (bus.done === 1'b1) begin
        done_t = t;
        done_cnt++;
        break;
      end
      step();
      t++;
    end
  endtask

  function automatic int countCodes(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    foreach (trace[i]) if (trace[i] == a || trace[i] == b) n++;
    return n;
  endfunction

  task automatic checkInitSequence(input string tag);
    int dones = 0;
    logic [7:0] exp_codes[4] = '{8'h09, 8'h0B, 8'h05, 8'h0D};
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.done === 1'b1) dones++;
      checkOutput($sformatf("%s_init%0d", tag, i), {24'd0, bus.avr_ctrl}, {24'd0, exp_codes[i]});
    end
    step();
    checkOutput({tag, "_idle_ctrl"}, {24'd0, bus.avr_ctrl}, 32'h01);
    checkOutput({tag, "_idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
    checkOutput({tag, "_no_done"}, dones, 0);
  endtask

  initial begin
    logic [23:0] addr_obs;
    int si_bad, seq_bad, exp_len, n_bytes;
    logic [7:0] exp_seq[$];

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = 8'd0;

    // Reset state
    avr_reset = 1'b1;
    step(); step(); step();
    checkOutput("rst_ctrl", {24'd0, bus.avr_ctrl}, 32'h01);
    checkOutput("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_strobe", {31'd0, bus.byte_strobe}, 32'd0);

    // Release, then re-assert partway through INIT: it must start over
    avr_reset = 1'b0;
    step();
    checkOutput("init_a0", {24'd0, bus.avr_ctrl}, 32'h09);
    step();
    checkOutput("init_a1", {24'd0, bus.avr_ctrl}, 32'h0B);
    avr_reset = 1'b1;
    step();
    checkOutput("init_rst_ctrl", {24'd0, bus.avr_ctrl}, 32'h01);
    avr_reset = 1'b0;
    checkInitSequence("init");

    // Single-byte read of 0xA50001
    applyStimulus(1'b0, 24'hA50001, 8'd1, 1'b0);
    runUntilDone(200);
    checkOutput("rd_open", {24'd0, trace[0]}, 32'h04);
    addr_obs = '0;
    si_bad = 0;
    for (int i = 1; i <= 24; i++) begin
      if (trace[i] != 8'h06 && trace[i] != 8'h07) si_bad++;
      addr_obs = {addr_obs[22:0], trace[i] == 8'h07};
    end
    checkOutput("rd_si_codes", si_bad, 0);
    checkOutput("rd_addr_bits", {8'd0, addr_obs}, 32'h00A50001);
    checkOutput("rd_close", {24'd0, trace[25]}, 32'h05);
    checkOutput("rd_oe_lo0", {24'd0, trace[26]}, 32'h08);
    checkOutput("rd_oe_lo1", {24'd0, trace[27]}, 32'h08);
    checkOutput("rd_oe_hi", {24'd0, trace[28]}, 32'h09);
    checkOutput("rd_done_t", done_t, 30);
    checkOutput("rd_strobe_t", first_strobe_t, 28);
    checkOutput("rd_strobes", strobe_cnt, 1);
    checkOutput("rd_done_ctrl", {24'd0, bus.avr_ctrl}, 32'h01);
    checkOutput("rd_done_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    checkOutput("rd_ready_t31", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("rd_done_pulse", {31'd0, bus.done}, 32'd0);

    // Write, len 3, req_valid held high for the whole transfer
`ifdef CMD_SEQ_BURST_EN
    n_bytes = 3;
`else
    n_bytes = 1;
`endif
    applyStimulus(1'b1, 24'h000000, 8'd3, 1'b1);
    runUntilDone(300);
    exp_seq.delete();
    for (int b = 0; b < n_bytes; b++) begin
      exp_seq.push_back(8'h0A); exp_seq.push_back(8'h0A); exp_seq.push_back(8'h0B);
      if (b != n_bytes - 1) begin exp_seq.push_back(8'h0C); exp_seq.push_back(8'h0D); end
    end
    exp_seq.push_back(8'h01);
    exp_len = 26 + exp_seq.size();
    checkOutput("wr_trace_len", trace.size(), exp_len);
    seq_bad = 0;
    foreach (exp_seq[i]) if (26 + i >= trace.size() || trace[26 + i] != exp_seq[i]) seq_bad++;
    checkOutput("wr_strobe_seq", seq_bad, 0);
    checkOutput("wr_strobes", strobe_cnt, n_bytes);
    checkOutput("wr_done_cnt", done_cnt, 1);
    checkOutput("wr_done_t", done_t, 30 + 5 * (n_bytes - 1));
    checkOutput("wr_no_ready", ready_seen, 0);
    checkOutput("wr_no_reopen", countCodes(8'h04, 8'h04), 1);

    // Held req_valid starts the next transfer only once req_ready returns
    step();
    checkOutput("hold_ready", {31'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    checkOutput("hold_restart", {24'd0, bus.avr_ctrl}, 32'h04);

    // Mid-transfer reset: byte 2 strobe-low in bursts, address shift otherwise
    done_cnt = 0;
`ifdef CMD_SEQ_BURST_EN
    for (int i = 1; i < 32; i++) begin step(); if (bus.done === 1'b1) done_cnt++; end
    checkOutput("mid_we_lo", {24'd0, bus.avr_ctrl}, 32'h0A);
`else
    for (int i = 1; i < 10; i++) begin step(); if (bus.done === 1'b1) done_cnt++; end
    checkOutput("mid_si_lo", {24'd0, bus.avr_ctrl}, 32'h06);
`endif
    avr_reset = 1'b1;
    step();
    avr_reset = 1'b0;
    checkOutput("mid_rst_ctrl", {24'd0, bus.avr_ctrl}, 32'h01);
    checkOutput("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    checkOutput("mid_rst_strobe", {31'd0, bus.byte_strobe}, 32'd0);
    checkOutput("mid_no_done", done_cnt, 0);
    checkInitSequence("mid");

    // len 5: five bytes in bursts, one byte otherwise
`ifdef CMD_SEQ_BURST_EN
    n_bytes = 5;
`else
    n_bytes = 1;
`endif
    applyStimulus(1'b0, 24'h123456, 8'd5, 1'b0);
    runUntilDone(400);
    checkOutput("len5_strobes", strobe_cnt, n_bytes);
    checkOutput("len5_done_t", done_t, 30 + 5 * (n_bytes - 1));
    checkOutput("len5_counter_codes", countCodes(8'h0C, 8'h0D), 2 * (n_bytes - 1));
    checkOutput("len5_forbidden", countCodes(8'h02, 8'h03) + countCodes(8'h0E, 8'h0F), 0);
    step();

    // len 0 encodes 256 bytes
`ifdef CMD_SEQ_BURST_EN
    n_bytes = 256;
`else
    n_bytes = 1;
`endif
    applyStimulus(1'b1, 24'hFFFFFF, 8'd0, 1'b0);
    runUntilDone(2000);
    checkOutput("len0_strobes", strobe_cnt, n_bytes);
    checkOutput("len0_done_cnt", done_cnt, 1);
    checkOutput("len0_done_t", done_t, 30 + 5 * (n_bytes - 1));
    checkOutput("len0_counter_codes", countCodes(8'h0C, 8'h0D), 2 * (n_bytes - 1));
    step();
    checkOutput("len0_ready_after", {31'd0, bus.req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
